// File: rtl/apb_regw_pkg.sv
// -----------------------------------------------------------------------------
// apb_regw_pkg
//   Shared definitions for the APB front-end of the regw register slices:
//   - state_t     : APB transfer FSM states
//   - CNT_W       : width of the wait-state counter (WAIT_CYC range 0..15)
//   - MAX_REGWN   : widest select vector the onehot() helper can build
//   - idx_width() : width of a slice index for a given slice count
//   - onehot()    : index -> one-hot vector (all-zero when out of range)
// -----------------------------------------------------------------------------
package apb_regw_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_t;

   localparam int CNT_W     = 4;
   localparam int MAX_REGWN = 32;
   localparam int OH_IDX_W  = 5;  // log2(MAX_REGWN)

   // A single-slice build still needs a 1-bit index.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic logic [MAX_REGWN-1:0] onehot(input logic [31:0] idx);
      logic [MAX_REGWN-1:0] v;
      v = '0;
      if (idx < 32'(MAX_REGWN)) v[idx[OH_IDX_W-1:0]] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/apb_regw_dec.sv
// -----------------------------------------------------------------------------
// apb_regw_dec
//   Combinational APB address decoder for the regw slices. Slice i lives at
//   BASE_ADDR+i. Addresses below BASE_ADDR (which wrap around when the base is
//   subtracted) and addresses at or beyond BASE_ADDR+REGWN are misses.
//
// Ports:
//   i_addr    in   AWIDTH  APB address
//   o_onehot  out  REGWN   one-hot slice select, all-zero on a miss
//   o_idx     out  IDX_W   slice index (meaningful only when o_hit=1)
//   o_hit     out  1       address falls inside the slice window
// -----------------------------------------------------------------------------
module apb_regw_dec
   import apb_regw_pkg::*;
#(
   parameter int AWIDTH    = 8,
   parameter int REGWN     = 5,
   parameter int BASE_ADDR = 0,
   parameter int IDX_W     = 3
) (
   input  logic [AWIDTH-1:0] i_addr,
   output logic [REGWN-1:0]  o_onehot,
   output logic [IDX_W-1:0]  o_idx,
   output logic              o_hit
);

   logic [AWIDTH-1:0] w_base;
   logic [AWIDTH-1:0] w_diff;

   assign w_base = AWIDTH'(BASE_ADDR);
   assign w_diff = i_addr - w_base;

   // The lower-bound compare is what rejects addresses that wrap below the
   // base; the difference alone cannot tell them apart from large offsets.
   assign o_hit    = (i_addr >= w_base) && (w_diff < AWIDTH'(REGWN));
   assign o_idx    = IDX_W'(w_diff);
   assign o_onehot = o_hit ? REGWN'(onehot(32'(w_diff))) : '0;

endmodule

// File: rtl/apb_regw_ctrl.sv
// -----------------------------------------------------------------------------
// apb_regw_ctrl
//   APB slave front-end for the regw register slices. Tracks the APB transfer
//   with an IDLE/SETUP/ACCESS FSM, drives one-hot read/write selects to the
//   slices during the setup phase, inserts WAIT_CYC wait states before a
//   registered PREADY, flags out-of-window addresses with PSLVERR and returns
//   the addressed slice's read data on PRDATA.
//
//   Transfer timeline with WAIT_CYC=N (bus setup cycle = FSM IDLE):
//     IDLE (PSEL=1,PENABLE=0) -> SETUP -> ACCESS x (N+1), PREADY in the last.
//
// Ports:
//   PCLK       in   1             clock, rising edge
//   PRESET     in   1             synchronous active-high reset
//   PSEL       in   1             APB select
//   PENABLE    in   1             APB enable
//   PWRITE     in   1             1 = write, 0 = read
//   PADDR      in   AWIDTH        APB address
//   pselw_r    out  REGWN         one-hot read select to the slices
//   pselw_w    out  REGWN         one-hot write select to the slices
//   slv_rdata  in   REGWN*DWIDTH  slice read data, slice i at [i*DWIDTH +: DWIDTH]
//   PRDATA     out  DWIDTH        bus read data (registered)
//   PREADY     out  1             transfer-complete strobe (registered)
//   PSLVERR    out  1             error response, only with PREADY (registered)
// -----------------------------------------------------------------------------
module apb_regw_ctrl
   import apb_regw_pkg::*;
#(
   parameter int DWIDTH    = 8,
   parameter int AWIDTH    = 8,
   parameter int REGWN     = 5,
   parameter int BASE_ADDR = 0,
   parameter int WAIT_CYC  = 0
) (
   input  logic                    PCLK,
   input  logic                    PRESET,
   input  logic                    PSEL,
   input  logic                    PENABLE,
   input  logic                    PWRITE,
   input  logic [AWIDTH-1:0]       PADDR,
   output logic [REGWN-1:0]        pselw_r,
   output logic [REGWN-1:0]        pselw_w,
   input  logic [REGWN*DWIDTH-1:0] slv_rdata,
   output logic [DWIDTH-1:0]       PRDATA,
   output logic                    PREADY,
   output logic                    PSLVERR
);

   localparam int                IDX_W    = idx_width(REGWN);
   localparam logic [CNT_W-1:0]  WAIT_LIM = CNT_W'(WAIT_CYC);

   // Registered transfer context
   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [IDX_W-1:0]   r_idx;
   logic               r_hit;
   logic               r_write;

   // Next-state values
   state_t             w_state_nxt;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic [CNT_W-1:0]   w_cnt_inc;
   logic [IDX_W-1:0]   w_idx_nxt;
   logic               w_hit_nxt;
   logic               w_write_nxt;
   logic               w_ready_nxt;
   logic               w_err_nxt;
   logic [DWIDTH-1:0]  w_rdata_nxt;
   logic               w_start;

   // Decoder and read mux
   logic [REGWN-1:0]   w_dec_oh;
   logic [IDX_W-1:0]   w_dec_idx;
   logic               w_dec_hit;
   logic               w_sel_en;
   logic [DWIDTH-1:0]  w_slice;

   // ---------------------------------------------------------------------------
   // Address decode of the live bus address; feeds both the selects and the
   // context latched at the start of a transfer.
   // ---------------------------------------------------------------------------
   apb_regw_dec #(
      .AWIDTH    (AWIDTH),
      .REGWN     (REGWN),
      .BASE_ADDR (BASE_ADDR),
      .IDX_W     (IDX_W)
   ) u_dec (
      .i_addr   (PADDR),
      .o_onehot (w_dec_oh),
      .o_idx    (w_dec_idx),
      .o_hit    (w_dec_hit)
   );

   // ---------------------------------------------------------------------------
   // Slice selects: live only while the FSM is waiting for or has just seen a
   // setup phase, so the slices sample them in the setup cycle. Forced low
   // during reset so a master holding PSEL cannot reach the slices.
   // ---------------------------------------------------------------------------
   assign w_sel_en = !PRESET && PSEL && ((r_state == IDLE) || (r_state == SETUP));
   assign pselw_w  = (w_sel_en &&  PWRITE) ? w_dec_oh : '0;
   assign pselw_r  = (w_sel_en && !PWRITE) ? w_dec_oh : '0;

   // ---------------------------------------------------------------------------
   // Read mux on the latched index; only consulted for latched hits, so an
   // out-of-range index never reaches PRDATA.
   // ---------------------------------------------------------------------------
   always_comb begin
      w_slice = '0;
      for (int i = 0; i < REGWN; i++) begin
         if (r_idx == IDX_W'(i)) w_slice = slv_rdata[i*DWIDTH +: DWIDTH];
      end
   end

   assign w_cnt_inc = r_cnt + CNT_W'(1);

   // ---------------------------------------------------------------------------
   // FSM next-state and registered-output next values
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path
      // through the case can leave one unassigned and infer a latch.
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_idx_nxt   = r_idx;
      w_hit_nxt   = r_hit;
      w_write_nxt = r_write;
      w_ready_nxt = 1'b0;
      w_err_nxt   = 1'b0;
      w_rdata_nxt = PRDATA;
      w_start     = 1'b0;

      case (r_state)
         IDLE: begin
            if (PSEL && !PENABLE) w_start = 1'b1;
         end

         SETUP: begin
            if (!PSEL) begin
               w_state_nxt = IDLE;               // aborted transfer
            end else begin
               w_state_nxt = ACCESS;
               w_ready_nxt = (WAIT_LIM == '0);   // zero waits: ready in 1st ACCESS
            end
         end

         ACCESS: begin
            if (!PSEL) begin
               w_state_nxt = IDLE;               // aborted, or master released bus
            end else if (PREADY) begin
               // Completing cycle: a new setup phase on the same edge chains
               // straight into the next transfer without passing IDLE.
               if (!PENABLE) w_start     = 1'b1;
               else          w_state_nxt = IDLE;
            end else begin
               // PREADY is registered, so it is raised on the edge where the
               // counter steps onto WAIT_CYC.
               w_cnt_nxt   = w_cnt_inc;
               w_ready_nxt = (w_cnt_inc == WAIT_LIM);
            end
         end

         default: w_state_nxt = IDLE;
      endcase

      if (w_start) begin
         w_state_nxt = SETUP;
         w_cnt_nxt   = '0;
         w_idx_nxt   = w_dec_idx;
         w_hit_nxt   = w_dec_hit;
         w_write_nxt = PWRITE;
      end

      // Response data is captured on the edge that enters the PREADY cycle;
      // writes and misses return zero.
      if (w_ready_nxt) begin
         w_err_nxt   = !r_hit;
         w_rdata_nxt = (r_hit && !r_write) ? w_slice : '0;
      end
   end

   // ---------------------------------------------------------------------------
   // State and registered outputs
   // ---------------------------------------------------------------------------
   always_ff @(posedge PCLK) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples its pre-edge inputs regardless of statement order.
      if (PRESET) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_hit   <= 1'b0;
         r_write <= 1'b0;
         PRDATA  <= '0;
         PREADY  <= 1'b0;
         PSLVERR <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_idx   <= w_idx_nxt;
         r_hit   <= w_hit_nxt;
         r_write <= w_write_nxt;
         PRDATA  <= w_rdata_nxt;
         PREADY  <= w_ready_nxt;
         PSLVERR <= w_err_nxt;
      end
   end

endmodule
